// File: rtl/ads79xx_pkg.sv
// Shared constants for the ADS79xx scan sequencer: SPI register map, status bits,
// sequencer state encoding and the manual-mode frame-word builder.
package ads79xx_pkg;

  localparam logic [1:0] OFS_DATA   = 2'b00;
  localparam logic [1:0] OFS_CTRL   = 2'b01;
  localparam logic [1:0] OFS_STATUS = 2'b10;

  localparam int unsigned RXNE = 0;
  localparam int unsigned TXE  = 1;

  localparam logic [3:0] MODE_MANUAL = 4'b0001;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCfg  = 3'd1;
  localparam logic [2:0] StWr   = 3'd2;
  localparam logic [2:0] StPoll = 3'd3;
  localparam logic [2:0] StRd   = 3'd4;
  localparam logic [2:0] StGap  = 3'd5;

  // Manual mode, program-enable set, channel select, range bit, GPIO bits zero.
  function automatic logic [15:0] frame_word(input logic [3:0] ch, input logic range_2x);
    return {MODE_MANUAL, 1'b1, ch, range_2x, 6'b000000};
  endfunction

endpackage

// File: rtl/ads79xx_bus_acc.sv
// Single-access bus master engine: one-cycle strobe, then wait for the acknowledge.
// Address, direction and write data stay latched from strobe through ack.
module ads79xx_bus_acc (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic [1:0]  m_addr_o,
  output logic [15:0] m_data_o,
  input  logic [15:0] m_data_i,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  logic        stb_q, stb_d;
  logic        wait_q, wait_d;
  logic        we_q, we_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  always_comb begin
    stb_d   = 1'b0;
    wait_d  = wait_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (!stb_q && !wait_q && req_i) begin
      stb_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
    if (stb_q) begin
      wait_d = 1'b1;
    end
    if (wait_q && m_ack_i) begin
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stb_q   <= 1'b0;
      wait_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= 16'h0000;
    end else begin
      stb_q   <= stb_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data is consumed by the caller in the ack cycle itself.
  assign done_o   = wait_q & m_ack_i;
  assign rdata_o  = m_data_i;
  assign m_addr_o = addr_q;
  assign m_data_o = wdata_q;
  assign m_we_o   = we_q;
  assign m_cyc_o  = stb_q;
  assign m_stb_o  = stb_q;

endmodule

// File: rtl/ads79xx_scan_seq.sv
// Autonomous ADS79xx scan sequencer: configures the SPI core once, then runs manual-mode
// frames over all channels, hiding the ADC's two-frame result latency with flush frames.
module ads79xx_scan_seq
  import ads79xx_pkg::*;
#(
  parameter int unsigned NUM_CH       = 16,
  parameter logic [15:0] CTRL_WORD    = 16'h084C,
  parameter logic        RANGE_2X     = 1'b0,
  parameter int unsigned FRAME_GAP    = 8,
  parameter int unsigned POLL_TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        cont_i,
  output logic        busy_o,
  output logic        err_o,
  output logic        res_valid_o,
  output logic [3:0]  res_ch_o,
  output logic [11:0] res_data_o,
  output logic        scan_done_o,
  output logic [1:0]  m_addr_o,
  output logic [15:0] m_data_o,
  input  logic [15:0] m_data_i,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  localparam logic [4:0]  FcLast  = 5'(NUM_CH + 2);
  localparam logic [3:0]  ChLast  = 4'(NUM_CH - 1);
  localparam logic [7:0]  GapLast = 8'(FRAME_GAP - 1);
  localparam logic [15:0] TmoLim  = 16'(POLL_TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic        cfg_q, cfg_d;
  logic        err_q, err_d;
  logic        issued_q, issued_d;
  logic [4:0]  fc_q, fc_d;
  logic [3:0]  ch_q, ch_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;

  logic        acc_req, acc_we, acc_done;
  logic [1:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata;
  logic        res_valid, scan_done;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    err_d     = err_q;
    fc_d      = fc_q;
    ch_d      = ch_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = OFS_DATA;
    acc_wdata = 16'h0000;
    res_valid = 1'b0;
    scan_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d   = 1'b0;
          fc_d    = 5'd0;
          ch_d    = 4'd0;
          state_d = cfg_q ? StWr : StCfg;
        end
      end
      StCfg: begin
        acc_req   = !issued_q;
        acc_we    = 1'b1;
        acc_addr  = OFS_CTRL;
        acc_wdata = CTRL_WORD;
        if (acc_done) begin
          cfg_d   = 1'b1;
          state_d = StWr;
        end
      end
      StWr: begin
        acc_req   = !issued_q;
        acc_we    = 1'b1;
        acc_addr  = OFS_DATA;
        acc_wdata = frame_word(ch_q, RANGE_2X);
        if (acc_done) begin
          tmo_d   = 16'd0;
          state_d = StPoll;
        end
      end
      StPoll: begin
        acc_req  = !issued_q;
        acc_addr = OFS_STATUS;
        tmo_d    = tmo_q + 16'd1;
        // Timeout is judged only at a poll ack so the bus engine is always idle on exit.
        if (acc_done) begin
          if (acc_rdata[RXNE]) begin
            state_d = StRd;
          end else if (tmo_q >= TmoLim) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRd: begin
        acc_req  = !issued_q;
        acc_addr = OFS_DATA;
        if (acc_done) begin
          res_valid = (fc_q >= 5'd2);
          fc_d      = fc_q + 5'd1;
          ch_d      = (ch_q == ChLast) ? ch_q : ch_q + 4'd1;
          gap_d     = 8'd0;
          state_d   = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GapLast) begin
          if (fc_q < FcLast) begin
            state_d = StWr;
          end else begin
            scan_done = 1'b1;
            if (cont_i) begin
              fc_d    = 5'd0;
              ch_d    = 4'd0;
              state_d = StWr;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issued_d = issued_q;
    if (acc_done) begin
      issued_d = 1'b0;
    end else if (acc_req) begin
      issued_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      cfg_q    <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
      fc_q     <= 5'd0;
      ch_q     <= 4'd0;
      gap_q    <= 8'd0;
      tmo_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      issued_q <= issued_d;
      fc_q     <= fc_d;
      ch_q     <= ch_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
    end
  end

  ads79xx_bus_acc u_bus_acc (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (acc_req),
    .we_i     (acc_we),
    .addr_i   (acc_addr),
    .wdata_i  (acc_wdata),
    .done_o   (acc_done),
    .rdata_o  (acc_rdata),
    .m_addr_o (m_addr_o),
    .m_data_o (m_data_o),
    .m_data_i (m_data_i),
    .m_we_o   (m_we_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i)
  );

  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;
  assign res_valid_o = res_valid;
  assign res_ch_o    = res_valid ? acc_rdata[15:12] : 4'h0;
  assign res_data_o  = res_valid ? acc_rdata[11:0] : 12'h000;
  assign scan_done_o = scan_done;

endmodule

// File: tb/tb_ads79xx_scan_seq.sv
// Bench for ads79xx_scan_seq: SPI/ADC slave model with random latency, a bus monitor
// and per-scenario tasks checking against expectations derived from the channel order.
module tb_ads79xx_scan_seq;
  import ads79xx_pkg::*;

  localparam int NCH = 4;
  localparam int GAP = 8;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy_o, err_o, res_valid_o, scan_done_o;
  logic [3:0]  res_ch_o;
  logic [11:0] res_data_o;
  logic [1:0]  m_addr_o;
  logic [15:0] m_data_o;
  logic [15:0] m_data_in = 16'h0000;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack = 1'b0;

  always #5 clk = ~clk;

  ads79xx_scan_seq #(
    .NUM_CH       (NCH),
    .FRAME_GAP    (GAP),
    .POLL_TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .cont_i      (cont),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .res_valid_o (res_valid_o),
    .res_ch_o    (res_ch_o),
    .res_data_o  (res_data_o),
    .scan_done_o (scan_done_o),
    .m_addr_o    (m_addr_o),
    .m_data_o    (m_data_o),
    .m_data_i    (m_data_in),
    .m_we_o      (m_we_o),
    .m_cyc_o     (m_cyc_o),
    .m_stb_o     (m_stb_o),
    .m_ack_i     (m_ack)
  );

  int n_checks = 0;
  int n_pass = 0;

  // SPI core + ADC model: a data read returns the conversion of the frame two frames back.
  bit         no_rxne = 1'b0;
  logic       rxne = 1'b0;
  int         lat = 0;
  logic [3:0] hist[$];

  initial forever begin
    logic [15:0] status;
    logic [3:0]  c;
    @(posedge clk);
    m_ack <= 1'b0;
    m_data_in <= 16'h0000;
    if (lat > 0) begin
      lat = lat - 1;
      if (lat == 0) rxne = 1'b1;
    end
    if (m_stb_o) begin
      m_ack <= 1'b1;
      if (m_we_o && m_addr_o == OFS_DATA) begin
        hist.push_back(m_data_o[10:7]);
        rxne = 1'b0;
        lat = no_rxne ? 0 : int'($urandom_range(1, 6));
      end else if (!m_we_o && m_addr_o == OFS_STATUS) begin
        status = 16'h0000;
        status[TXE] = 1'b1;
        status[RXNE] = rxne;
        m_data_in <= status;
      end else if (!m_we_o && m_addr_o == OFS_DATA) begin
        rxne = 1'b0;
        if (hist.size() >= 3) begin
          c = hist[hist.size() - 3];
          m_data_in <= {c, 12'hA00 + {8'h00, c}};
        end else begin
          m_data_in <= 16'hDEAD;
        end
      end
    end
  end

  // Bus/result monitor, sampling mid-cycle.
  int          cyc = 0;
  int          viol = 0;
  int          n_stb = 0;
  int          n_done = 0;
  int          last_ack = -100;
  bit          prev_stb = 1'b0;
  bit          outst = 1'b0;
  logic [18:0] acc_q[$];
  logic [15:0] frame_q[$];
  int          idle_q[$];
  logic [15:0] res_q[$];

  initial forever begin
    logic [1:0]  s_addr;
    logic        s_we;
    logic [15:0] s_data;
    @(negedge clk);
    cyc++;
    if (!rstn) begin
      outst = 1'b0;
      prev_stb = 1'b0;
    end else begin
      if (m_cyc_o !== m_stb_o) viol++;
      if (m_stb_o) begin
        n_stb++;
        if (prev_stb || m_ack || outst) viol++;
        outst = 1'b1;
        s_addr = m_addr_o;
        s_we = m_we_o;
        s_data = m_data_o;
        acc_q.push_back({m_we_o, m_addr_o, m_data_o});
        if (m_we_o && m_addr_o == OFS_DATA) begin
          frame_q.push_back(m_data_o);
          idle_q.push_back(cyc - last_ack - 1);
        end
      end
      if (m_ack) begin
        if (!outst || m_addr_o !== s_addr || m_we_o !== s_we || m_data_o !== s_data) viol++;
        outst = 1'b0;
        last_ack = cyc;
      end
      if (res_valid_o) res_q.push_back({res_ch_o, res_data_o});
      if (scan_done_o) n_done++;
      if (res_valid_o && scan_done_o) viol++;
      prev_stb = m_stb_o;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] exp_frame(input int i);
    int c;
    c = (i < NCH - 1) ? i : NCH - 1;
    return 16'(32'h1800 + 32'h80 * c);
  endfunction

  function automatic logic [15:0] exp_result(input int c);
    return 16'((c << 12) + 32'hA00 + c);
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_checks++;
    if ({m_cyc_o, m_stb_o, m_we_o} !== 3'b000)
      $display("FAIL reset_bus: got %b want 000", {m_cyc_o, m_stb_o, m_we_o});
    else n_pass++;
    n_checks++;
    if ({res_valid_o, scan_done_o} !== 2'b00)
      $display("FAIL reset_strobes: got %b want 00", {res_valid_o, scan_done_o});
    else n_pass++;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_scan(input string tag, input int f0, input int r0);
    n_checks++;
    if (frame_q.size() - f0 !== NCH + 2)
      $display("FAIL %s_frames: got %0d want %0d", tag, frame_q.size() - f0, NCH + 2);
    else n_pass++;
    for (int i = 0; i < NCH + 2; i++) begin
      n_checks++;
      if (frame_q[f0 + i] !== exp_frame(i))
        $display("FAIL %s_frame%0d: got %h want %h", tag, i, frame_q[f0 + i], exp_frame(i));
      else n_pass++;
    end
    n_checks++;
    if (res_q.size() - r0 !== NCH)
      $display("FAIL %s_nres: got %0d want %0d", tag, res_q.size() - r0, NCH);
    else n_pass++;
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (res_q[r0 + c] !== exp_result(c))
        $display("FAIL %s_res%0d: got %h want %h", tag, c, res_q[r0 + c], exp_result(c));
      else n_pass++;
    end
  endtask

  task automatic test_first_scan();
    int a0 = acc_q.size();
    int f0 = frame_q.size();
    int r0 = res_q.size();
    int d0 = n_done;
    bit ok;
    pulse_start();
    wait_done(d0 + 1, 3000, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL first_done: got timeout want scan_done"); else n_pass++;
    wait_idle(20, ok);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL first_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++;
    if (acc_q[a0] !== {1'b1, OFS_CTRL, 16'h084C})
      $display("FAIL first_cfg: got %h want %h", acc_q[a0], {1'b1, OFS_CTRL, 16'h084C});
    else n_pass++;
    check_scan("first", f0, r0);
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL first_ndone: got %0d want 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_second_scan();
    int a0 = acc_q.size();
    int f0 = frame_q.size();
    int r0 = res_q.size();
    bit ok;
    pulse_start();
    wait_done(n_done + 1, 3000, ok);
    wait_idle(20, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL second_idle: got timeout want idle"); else n_pass++;
    n_checks++;
    if (acc_q[a0] !== {1'b1, OFS_DATA, 16'h1800})
      $display("FAIL second_first_acc: got %h want %h", acc_q[a0], {1'b1, OFS_DATA, 16'h1800});
    else n_pass++;
    check_scan("second", f0, r0);
  endtask

  task automatic test_timeout();
    int r0 = res_q.size();
    int t0;
    bit ok;
    no_rxne = 1'b1;
    t0 = cyc;
    pulse_start();
    wait_idle(TMO + 200, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL tmo_idle: got busy want idle"); else n_pass++;
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_o); else n_pass++;
    n_checks++;
    if (cyc - t0 < TMO || cyc - t0 > TMO + 60)
      $display("FAIL tmo_cycles: got %0d want %0d..%0d", cyc - t0, TMO, TMO + 60);
    else n_pass++;
    n_checks++;
    if (res_q.size() !== r0) $display("FAIL tmo_nores: got %0d want %0d", res_q.size(), r0);
    else n_pass++;
    no_rxne = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err_o); else n_pass++;
    pulse_start();
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err_o); else n_pass++;
    wait_done(n_done + 1, 3000, ok);
    wait_idle(20, ok);
    n_checks++;
    if (res_q.size() - r0 !== NCH)
      $display("FAIL tmo_recover: got %0d want %0d", res_q.size() - r0, NCH);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0 = frame_q.size();
    int r0 = res_q.size();
    int d0 = n_done;
    bit ok;
    cont = 1'b1;
    pulse_start();
    wait_done(d0 + 1, 3000, ok);
    repeat (5) @(negedge clk);
    cont = 1'b0;
    wait_done(d0 + 2, 3000, ok);
    wait_idle(20, ok);
    n_checks++;
    if (n_done - d0 !== 2) $display("FAIL b2b_ndone: got %0d want 2", n_done - d0); else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++;
    if (res_q.size() - r0 !== 2 * NCH)
      $display("FAIL b2b_nres: got %0d want %0d", res_q.size() - r0, 2 * NCH);
    else n_pass++;
    for (int k = 0; k < 2 * NCH; k++) begin
      n_checks++;
      if (res_q[r0 + k] !== exp_result(k % NCH))
        $display("FAIL b2b_res%0d: got %h want %h", k, res_q[r0 + k], exp_result(k % NCH));
      else n_pass++;
    end
    n_checks++;
    if (frame_q.size() - f0 !== 2 * (NCH + 2))
      $display("FAIL b2b_frames: got %0d want %0d", frame_q.size() - f0, 2 * (NCH + 2));
    else n_pass++;
    for (int i = 1; i < 2 * (NCH + 2); i++) begin
      n_checks++;
      if (idle_q[f0 + i] < GAP || idle_q[f0 + i] > GAP + 3)
        $display("FAIL b2b_gap%0d: got %0d idle want %0d..%0d", i, idle_q[f0 + i], GAP, GAP + 3);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    int f0 = frame_q.size();
    int r0 = res_q.size();
    int d0 = n_done;
    bit ok;
    pulse_start();
    repeat (25) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL ign_busy: got %b want 1", busy_o); else n_pass++;
    pulse_start();
    wait_done(d0 + 1, 3000, ok);
    wait_idle(20, ok);
    repeat (40) @(negedge clk);
    n_checks++;
    if (frame_q.size() - f0 !== NCH + 2)
      $display("FAIL ign_frames: got %0d want %0d", frame_q.size() - f0, NCH + 2);
    else n_pass++;
    n_checks++;
    if (res_q.size() - r0 !== NCH)
      $display("FAIL ign_nres: got %0d want %0d", res_q.size() - r0, NCH);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1 || busy_o !== 1'b0)
      $display("FAIL ign_done: got %0d/%b want 1/0", n_done - d0, busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_midscan();
    int a0;
    int r0;
    bit ok;
    pulse_start();
    repeat (30) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, m_stb_o} !== 2'b00)
      $display("FAIL rst_abort: got %b want 00", {busy_o, m_stb_o});
    else n_pass++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    a0 = acc_q.size();
    r0 = res_q.size();
    pulse_start();
    wait_done(n_done + 1, 3000, ok);
    wait_idle(20, ok);
    n_checks++;
    if (acc_q[a0] !== {1'b1, OFS_CTRL, 16'h084C})
      $display("FAIL rst_recfg: got %h want %h", acc_q[a0], {1'b1, OFS_CTRL, 16'h084C});
    else n_pass++;
    n_checks++;
    if (res_q.size() - r0 !== NCH)
      $display("FAIL rst_nres: got %0d want %0d", res_q.size() - r0, NCH);
    else n_pass++;
  endtask

  task automatic test_bus_protocol();
    n_checks++;
    if (viol !== 0) $display("FAIL bus_protocol: got %0d violations want 0", viol); else n_pass++;
    n_checks++;
    if (n_stb < 50) $display("FAIL bus_activity: got %0d strobes want >=50", n_stb); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_scan();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    test_second_scan();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    test_timeout();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    test_back_to_back();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    test_start_ignored();
    test_reset_midscan();
    test_bus_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
